// File: rtl/tlb_plru_asid.sv
// Fully-associative Sv32 TLB with ASID/global matching, tree-PLRU replacement
// and single-cycle SFENCE.VMA flush. Lookups respond one cycle later.
module tlb_plru_asid #(
  parameter int ENTRIES = 32,
  parameter int ASID_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid_i,
  output logic              lookup_ready_o,
  input  logic [31:0]       vaddr_i,
  input  logic [ASID_W-1:0] asid_i,
  output logic              resp_valid_o,
  output logic              hit_o,
  output logic [33:0]       paddr_o,
  output logic [6:0]        perm_o,
  output logic              is_superpage_o,
  input  logic              fill_req_i,
  input  logic [19:0]       fill_vpn_i,
  input  logic [ASID_W-1:0] fill_asid_i,
  input  logic [21:0]       fill_ppn_i,
  input  logic [6:0]        fill_perm_i,
  input  logic              fill_superpage_i,
  input  logic              flush_req_i,
  input  logic              flush_use_vpn_i,
  input  logic              flush_use_asid_i,
  input  logic [19:0]       flush_vpn_i,
  input  logic [ASID_W-1:0] flush_asid_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int NODES = ENTRIES - 1;

  logic [ENTRIES-1:0] r_valid;
  logic [19:0]        r_vpn   [ENTRIES];
  logic [ASID_W-1:0]  r_asid  [ENTRIES];
  logic [21:0]        r_ppn   [ENTRIES];
  logic [6:0]         r_perm  [ENTRIES];
  logic               r_super [ENTRIES];
  logic [NODES-1:0]   r_plru;

  logic [ENTRIES-1:0] w_lk_match;
  logic [ENTRIES-1:0] w_fl_match;
  logic               w_hit;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_has_inv;
  logic [IDX_W-1:0]   w_inv_idx;
  logic [IDX_W-1:0]   w_plru_vic;
  logic [IDX_W-1:0]   w_fill_idx;
  logic               w_lk_acc;
  logic               w_fill_en;
  logic [33:0]        w_paddr;

  // Handshake: a lookup is accepted in any cycle where lookup_valid_i && lookup_ready_o;
  // the response strobe follows exactly one cycle later and cannot be stalled.
  assign lookup_ready_o = !flush_req_i;
  assign w_lk_acc       = lookup_valid_i && lookup_ready_o;
  assign w_fill_en      = fill_req_i && !flush_req_i;

  // Mark every node on idx's path so that it points at the other half.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] cur,
                                                  input logic [IDX_W-1:0] idx);
    int   node;
    logic b;
    plru_touch = cur;
    node = 0;
    for (int l = 0; l < IDX_W; l++) begin
      b = idx[IDX_W-1-l];
      plru_touch[node] = ~b;
      node = 2 * node + 1 + int'(b);
    end
  endfunction

  always_comb begin
    w_lk_match = '0;
    w_fl_match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_lk_match[i] = r_valid[i]
                   && (r_perm[i][4] || (r_asid[i] == asid_i))
                   && (r_vpn[i][19:10] == vaddr_i[31:22])
                   && (r_super[i] || (r_vpn[i][9:0] == vaddr_i[21:12]));
      w_fl_match[i] = (!flush_use_vpn_i
                       || ((r_vpn[i][19:10] == flush_vpn_i[19:10])
                           && (r_super[i] || (r_vpn[i][9:0] == flush_vpn_i[9:0]))))
                   && (!flush_use_asid_i
                       || ((r_asid[i] == flush_asid_i) && !r_perm[i][4]));
    end
  end

  // Descending scans leave the lowest qualifying index as the winner.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_has_inv = 1'b0;
    w_inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_lk_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_has_inv = 1'b1;
        w_inv_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    int   node;
    logic b;
    w_plru_vic = '0;
    node = 0;
    for (int l = 0; l < IDX_W; l++) begin
      b = r_plru[node];
      w_plru_vic[IDX_W-1-l] = b;
      node = 2 * node + 1 + int'(b);
    end
  end

  assign w_fill_idx = w_has_inv ? w_inv_idx : w_plru_vic;

  always_comb begin
    if (r_super[w_hit_idx])
      w_paddr = {r_ppn[w_hit_idx][21:10], vaddr_i[21:0]};
    else
      w_paddr = {r_ppn[w_hit_idx], vaddr_i[11:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid        <= '0;
      r_plru         <= '0;
      resp_valid_o   <= 1'b0;
      hit_o          <= 1'b0;
      paddr_o        <= '0;
      perm_o         <= '0;
      is_superpage_o <= 1'b0;
    end else begin
      resp_valid_o <= w_lk_acc;
      if (w_lk_acc) begin
        hit_o          <= w_hit;
        paddr_o        <= w_hit ? w_paddr : '0;
        perm_o         <= w_hit ? r_perm[w_hit_idx] : '0;
        is_superpage_o <= w_hit && r_super[w_hit_idx];
      end
      // Flush beats fill beats lookup-hit for valid and PLRU updates.
      if (flush_req_i) begin
        r_valid <= r_valid & ~w_fl_match;
      end else if (fill_req_i) begin
        r_valid[w_fill_idx] <= 1'b1;
        r_plru              <= plru_touch(r_plru, w_fill_idx);
      end else if (w_lk_acc && w_hit) begin
        r_plru <= plru_touch(r_plru, w_hit_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_en) begin
      r_vpn[w_fill_idx]   <= fill_vpn_i;
      r_asid[w_fill_idx]  <= fill_asid_i;
      r_ppn[w_fill_idx]   <= fill_ppn_i;
      r_perm[w_fill_idx]  <= fill_perm_i;
      r_super[w_fill_idx] <= fill_superpage_i;
    end
  end

endmodule

// File: tb/tb_tlb_plru_asid.sv
// Directed bench for tlb_plru_asid (4 entries): expected responses are queued
// when a lookup is driven and compared when the response strobe appears.
module tb_tlb_plru_asid;

  localparam int ASID_W = 9;
  localparam int EXP_W  = 43;

  logic              clk;
  logic              rst;
  logic              lookup_valid_i;
  logic              lookup_ready_o;
  logic [31:0]       vaddr_i;
  logic [ASID_W-1:0] asid_i;
  logic              resp_valid_o;
  logic              hit_o;
  logic [33:0]       paddr_o;
  logic [6:0]        perm_o;
  logic              is_superpage_o;
  logic              fill_req_i;
  logic [19:0]       fill_vpn_i;
  logic [ASID_W-1:0] fill_asid_i;
  logic [21:0]       fill_ppn_i;
  logic [6:0]        fill_perm_i;
  logic              fill_superpage_i;
  logic              flush_req_i;
  logic              flush_use_vpn_i;
  logic              flush_use_asid_i;
  logic [19:0]       flush_vpn_i;
  logic [ASID_W-1:0] flush_asid_i;

  logic [EXP_W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  tlb_plru_asid #(.ENTRIES(4), .ASID_W(ASID_W)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .vaddr_i(vaddr_i), .asid_i(asid_i),
    .resp_valid_o(resp_valid_o), .hit_o(hit_o), .paddr_o(paddr_o),
    .perm_o(perm_o), .is_superpage_o(is_superpage_o),
    .fill_req_i(fill_req_i), .fill_vpn_i(fill_vpn_i), .fill_asid_i(fill_asid_i),
    .fill_ppn_i(fill_ppn_i), .fill_perm_i(fill_perm_i),
    .fill_superpage_i(fill_superpage_i),
    .flush_req_i(flush_req_i), .flush_use_vpn_i(flush_use_vpn_i),
    .flush_use_asid_i(flush_use_asid_i), .flush_vpn_i(flush_vpn_i),
    .flush_asid_i(flush_asid_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_fill(input logic [19:0] vpn, input logic [ASID_W-1:0] asid,
                         input logic [21:0] ppn, input logic [6:0] perm, input logic sp);
    fill_req_i = 1'b1; fill_vpn_i = vpn; fill_asid_i = asid;
    fill_ppn_i = ppn; fill_perm_i = perm; fill_superpage_i = sp;
    step();
    fill_req_i = 1'b0;
  endtask

  task automatic do_flush(input logic use_vpn, input logic use_asid,
                          input logic [19:0] vpn, input logic [ASID_W-1:0] asid);
    flush_req_i = 1'b1; flush_use_vpn_i = use_vpn; flush_use_asid_i = use_asid;
    flush_vpn_i = vpn; flush_asid_i = asid;
    step();
    flush_req_i = 1'b0;
  endtask

  // Drive one lookup, queue its expectation, then check the response a cycle later.
  task automatic do_lookup(input string tag, input logic [31:0] va, input logic [ASID_W-1:0] asid,
                           input logic e_hit, input logic [33:0] e_pa,
                           input logic [6:0] e_perm, input logic e_sp);
    logic [EXP_W-1:0] e;
    lookup_valid_i = 1'b1; vaddr_i = va; asid_i = asid;
    exp_q.push_back({e_hit, e_pa, e_perm, e_sp});
    step();
    lookup_valid_i = 1'b0;
    chk({tag, ".valid"}, 64'(resp_valid_o), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".hit"},   64'(hit_o),          64'(e[42]));
      chk({tag, ".paddr"}, 64'(paddr_o),        64'(e[41:8]));
      chk({tag, ".perm"},  64'(perm_o),         64'(e[7:1]));
      chk({tag, ".sp"},    64'(is_superpage_o), 64'(e[0]));
    end
  endtask

  task automatic miss(input string tag, input logic [31:0] va, input logic [ASID_W-1:0] asid);
    do_lookup(tag, va, asid, 1'b0, 34'd0, 7'd0, 1'b0);
  endtask

  task automatic hit4k(input string tag, input logic [31:0] va, input logic [ASID_W-1:0] asid,
                       input logic [21:0] ppn, input logic [6:0] perm);
    do_lookup(tag, va, asid, 1'b1, {ppn, va[11:0]}, perm, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    lookup_valid_i = 1'b0; vaddr_i = '0; asid_i = '0;
    fill_req_i = 1'b0; fill_vpn_i = '0; fill_asid_i = '0; fill_ppn_i = '0;
    fill_perm_i = '0; fill_superpage_i = 1'b0;
    flush_req_i = 1'b0; flush_use_vpn_i = 1'b0; flush_use_asid_i = 1'b0;
    flush_vpn_i = '0; flush_asid_i = '0;

    // reset state
    step(); step();
    chk("rst.resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst.hit",        64'(hit_o),        64'd0);
    chk("rst.paddr",      64'(paddr_o),      64'd0);
    chk("rst.perm",       64'(perm_o),       64'd0);
    chk("rst.sp",         64'(is_superpage_o), 64'd0);
    chk("rst.ready",      64'(lookup_ready_o), 64'd1);
    flush_req_i = 1'b1; #1;
    chk("rst.ready_flush", 64'(lookup_ready_o), 64'd0);
    flush_req_i = 1'b0;
    rst = 1'b0;
    step();
    miss("rst.empty", 32'h1234_5678, 9'd3);

    // basic translation
    do_fill(20'h12345, 9'd3, 22'h2ABCD, 7'h0F, 1'b0);
    hit4k("basic", 32'h1234_5678, 9'd3, 22'h2ABCD, 7'h0F);
    step();
    chk("basic.strobe_once", 64'(resp_valid_o), 64'd0);

    // ASID mismatch, then global entry
    miss("asid.other", 32'h1234_5678, 9'd4);
    do_flush(1'b0, 1'b0, 20'h0, 9'd0);
    miss("flush_all", 32'h1234_5678, 9'd3);
    do_fill(20'h12345, 9'd3, 22'h2ABCD, 7'h1F, 1'b0);
    hit4k("global", 32'h1234_5678, 9'd4, 22'h2ABCD, 7'h1F);

    // superpage
    do_fill(20'h80000, 9'd0, 22'h3FF000, 7'h0F, 1'b1);
    do_lookup("super", 32'h803F_F123, 9'd0, 1'b1, 34'h3_FF3F_F123, 7'h0F, 1'b1);
    do_lookup("super.vpn0", 32'h8000_0ABC, 9'd0, 1'b1, 34'h3_FF00_0ABC, 7'h0F, 1'b1);

    // lowest index wins on duplicates
    do_flush(1'b0, 1'b0, 20'h0, 9'd0);
    do_fill(20'h00777, 9'd1, 22'h00111, 7'h07, 1'b0);
    do_fill(20'h00777, 9'd1, 22'h00222, 7'h03, 1'b0);
    hit4k("dup.lowest", 32'h0077_7010, 9'd1, 22'h00111, 7'h07);

    // PLRU replacement: A,B,C,D then touch A, E must evict C
    do_flush(1'b0, 1'b0, 20'h0, 9'd0);
    do_fill(20'h00001, 9'd1, 22'h0000A, 7'h07, 1'b0);
    do_fill(20'h00002, 9'd1, 22'h0000B, 7'h07, 1'b0);
    do_fill(20'h00003, 9'd1, 22'h0000C, 7'h07, 1'b0);
    do_fill(20'h00004, 9'd1, 22'h0000D, 7'h07, 1'b0);
    hit4k("plru.A0", 32'h0000_1004, 9'd1, 22'h0000A, 7'h07);
    do_fill(20'h00005, 9'd1, 22'h0000E, 7'h07, 1'b0);
    miss("plru.C_evicted", 32'h0000_3004, 9'd1);
    hit4k("plru.E", 32'h0000_5008, 9'd1, 22'h0000E, 7'h07);
    hit4k("plru.A", 32'h0000_1FFF, 9'd1, 22'h0000A, 7'h07);
    hit4k("plru.B", 32'h0000_2000, 9'd1, 22'h0000B, 7'h07);
    hit4k("plru.D", 32'h0000_4123, 9'd1, 22'h0000D, 7'h07);

    // selective flush
    do_flush(1'b0, 1'b0, 20'h0, 9'd0);
    do_fill(20'h00100, 9'd5, 22'h00100, 7'h17, 1'b0);
    do_fill(20'h00200, 9'd1, 22'h00200, 7'h07, 1'b0);
    do_fill(20'h00300, 9'd2, 22'h00300, 7'h07, 1'b0);
    do_flush(1'b0, 1'b1, 20'h0, 9'd1);
    miss("sel.X", 32'h0020_0000, 9'd1);
    hit4k("sel.Y", 32'h0030_0444, 9'd2, 22'h00300, 7'h07);
    hit4k("sel.G1", 32'h0010_0555, 9'd9, 22'h00100, 7'h17);
    do_flush(1'b1, 1'b1, 20'h00100, 9'd5);
    hit4k("sel.G1_kept", 32'h0010_0555, 9'd9, 22'h00100, 7'h17);
    do_flush(1'b1, 1'b0, 20'h00100, 9'd0);
    miss("sel.G1_gone", 32'h0010_0555, 9'd5);
    do_flush(1'b1, 1'b1, 20'h00300, 9'd3);
    hit4k("sel.Y_kept", 32'h0030_0444, 9'd2, 22'h00300, 7'h07);
    do_flush(1'b1, 1'b1, 20'h00300, 9'd2);
    miss("sel.Y_gone", 32'h0030_0444, 9'd2);

    // flush and fill collide: fill dropped, lookup not accepted
    fill_req_i = 1'b1; fill_vpn_i = 20'h0AAAA; fill_asid_i = 9'd1;
    fill_ppn_i = 22'h0AAAA; fill_perm_i = 7'h07; fill_superpage_i = 1'b0;
    flush_req_i = 1'b1; flush_use_vpn_i = 1'b1; flush_use_asid_i = 1'b0;
    flush_vpn_i = 20'h0BBBB;
    lookup_valid_i = 1'b1; vaddr_i = 32'h0AAA_A000; asid_i = 9'd1;
    #1;
    chk("coll.ready", 64'(lookup_ready_o), 64'd0);
    step();
    fill_req_i = 1'b0; flush_req_i = 1'b0; lookup_valid_i = 1'b0;
    chk("coll.no_resp", 64'(resp_valid_o), 64'd0);
    miss("coll.not_written", 32'h0AAA_A000, 9'd1);

    // reset right after an accepted lookup discards the response
    do_fill(20'h0CCCC, 9'd1, 22'h0CCCC, 7'h07, 1'b0);
    lookup_valid_i = 1'b1; vaddr_i = 32'h0CCC_C000; asid_i = 9'd1;
    step();
    lookup_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst.inflight_valid", 64'(resp_valid_o), 64'd0);
    chk("rst.inflight_hit",   64'(hit_o),        64'd0);
    step();
    rst = 1'b0;
    step();
    miss("rst.after_C", 32'h0CCC_C000, 9'd1);
    miss("rst.after_Y", 32'h0030_0444, 9'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tlb_plru_asid.md
TLB_PLRU_ASID -- requirements
Module: tlb_plru_asid

Interface
REQ-001 SHALL have parameter ENTRIES, default 32, number of fully-associative entries (power of 2, 2..64).
REQ-002 SHALL have parameter ASID_W, default 9, ASID width (1..9).
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port lookup_valid_i  input  1  lookup request.
REQ-006 SHALL have port lookup_ready_o  output  1  lookup accepted when valid&&ready.
REQ-007 SHALL have port vaddr_i  input  32  virtual address to translate.
REQ-008 SHALL have port asid_i  input  ASID_W  current address-space ID.
REQ-009 SHALL have port resp_valid_o  output  1  one-cycle response strobe.
REQ-010 SHALL have port hit_o  output  1  response hit; valid only with resp_valid_o.
REQ-011 SHALL have port paddr_o  output  34  Sv32 physical address.
REQ-012 SHALL have port perm_o  output  7  {D,A,G,U,X,W,R} of hit entry.
REQ-013 SHALL have port is_superpage_o  output  1  hit entry is a 4 MiB page.
REQ-014 SHALL have port fill_req_i  input  1  one-cycle write request from the PTW.
REQ-015 SHALL have ports fill_vpn_i (20), fill_asid_i (ASID_W), fill_ppn_i (22), fill_perm_i (7), fill_superpage_i (1), all inputs, entry contents.
REQ-016 SHALL have port flush_req_i  input  1  SFENCE.VMA strobe.
REQ-017 SHALL have ports flush_use_vpn_i (1), flush_use_asid_i (1), flush_vpn_i (20), flush_asid_i (ASID_W), all inputs, flush qualifiers.

Function
REQ-018 Entry match SHALL be: valid && (perm[4] (G) || asid == asid_i) && vpn1 equal && (superpage || vpn0 equal).
REQ-019 Multiple matches SHALL resolve to the lowest index.
REQ-020 lookup_ready_o SHALL equal !flush_req_i.
REQ-021 Response SHALL be registered with latency 1: an accepted lookup in cycle N gives resp_valid_o=1 in cycle N+1 only; no backpressure.
REQ-022 Lookup SHALL use array contents before any same-cycle fill.
REQ-023 paddr_o SHALL be {ppn[21:10], vaddr[21:12], vaddr[11:0]} for superpages and {ppn, vaddr[11:0]} otherwise; on miss, paddr_o, perm_o and is_superpage_o SHALL be 0.
REQ-024 Replacement SHALL use a tree-PLRU of ENTRIES-1 bits; a node bit of 0 selects the lower-index half as victim.
REQ-025 On an accepted lookup hit and on every fill, the PLRU nodes on the entry's path SHALL be set to point away from that entry.
REQ-026 Fill victim SHALL be the lowest-index invalid entry if any exists, else the PLRU victim; the fill SHALL write all fields and set valid.
REQ-027 Fill SHALL NOT check for duplicates; avoiding them is the PTW's responsibility.
REQ-028 Flush SHALL complete in one cycle and select entries as follows:
  - use_vpn=0, use_asid=0: all entries.
  - use_vpn=0, use_asid=1: asid match and G=0.
  - use_vpn=1, use_asid=0: VPN match per REQ-018 VPN rule, any ASID.
  - use_vpn=1, use_asid=1: VPN match and asid match and G=0.
REQ-029 Priority SHALL be flush > fill > lookup PLRU update; a fill in a flush cycle SHALL be dropped.
REQ-030 PLRU state SHALL NOT change on flush.

Reset
REQ-031 On rst, all valid bits, all PLRU bits, resp_valid_o, hit_o, paddr_o, perm_o and is_superpage_o SHALL be 0.
REQ-032 On rst, lookup_ready_o SHALL follow REQ-020.
REQ-033 An in-flight lookup response SHALL be discarded on rst.
REQ-034 Entry data fields SHALL need no reset.

Verification
REQ-035 Basic translation: after reset, fill vpn 0x12345, asid 3, ppn 0x2ABCD, perm 0x0F; then lookup 0x12345678 with asid 3 -> next cycle resp_valid_o=1, hit_o=1, paddr_o=0x2ABCD678, perm_o=0x0F.
REQ-036 ASID and global: the same lookup with asid 4 -> hit_o=0, paddr_o=0. Refill with G=1 (perm 0x1F) after a full flush, then lookup with asid 4 -> hit_o=1.
REQ-037 Superpage: fill vpn 0x80000, superpage=1, ppn 0x3FF000; lookup 0x803FF123 -> paddr_o=0x3FF3FF123, is_superpage_o=1.
REQ-038 Replacement (ENTRIES=4): fill A,B,C,D into entries 0-3, look up A, then fill E -> E overwrites entry 2 (C); A, B and D still hit.
REQ-039 Selective flush: global entry G1 and non-global entries X (asid 1) and Y (asid 2); flush with use_asid=1, asid 1 -> X misses, Y and G1 hit. Flush with use_vpn=1, use_asid=0 on G1's vpn -> G1 misses.
REQ-040 Collisions: flush_req_i and fill_req_i in the same cycle -> entry not written and lookup_ready_o=0. rst asserted the cycle after a lookup -> resp_valid_o=0 and all lookups miss afterwards.
